// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with majority-vote sampling and held output word
module uart_rx_param #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sci_rx,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CW      = $clog2(BIT_CYC + 1);

    localparam logic [CW-1:0] C_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_S2   = CW'(HALF + 1);
    localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);
    localparam logic          S_FIN  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           sync_q;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 s0, s1, maj;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 perr_now;
    logic                 samp0, samp1, samp2, bit_end, final_stop, deliver;

    // Two-flop synchronizer; idle-high so reset must not fake a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], sci_rx};
    end
    assign rxs = sync_q[1];
    assign maj = (s0 & s1) | (s0 & rxs) | (s1 & rxs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rxs) state_nxt = S_START;
            S_START: begin
                if (samp2 && maj)  state_nxt = S_IDLE;
                else if (bit_end)  state_nxt = S_DATA;
            end
            S_DATA:   if (bit_end && bit_idx == B_LAST)
                          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP:   if (samp2 && final_stop)
                          state_nxt = (ferr_acc || !maj) ? S_BRK : S_IDLE;
            S_BRK:    if (rxs) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        samp0      = 1'b0;
        samp1      = 1'b0;
        samp2      = 1'b0;
        bit_end    = 1'b0;
        final_stop = (stop_idx == S_FIN);
        if (state != S_IDLE && state != S_BRK) begin
            samp0   = (cnt == C_S0);
            samp1   = (cnt == C_S1);
            samp2   = (cnt == C_S2);
            bit_end = (cnt == C_LAST);
        end
        deliver = (state == S_STOP) && samp2 && final_stop;
    end

    always_comb begin
        perr_now = 1'b0;
        case (PARITY)
            1:       perr_now = ~(^shreg ^ par_bit);
            2:       perr_now = ^shreg ^ par_bit;
            default: perr_now = 1'b0;
        endcase
    end

    // Counter restarts whenever the line FSM is (or is about to be) idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            if (state == S_IDLE || state == S_BRK || state_nxt == S_IDLE || bit_end)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (samp0) s0 <= rxs;
            if (samp1) s1 <= rxs;
            if (state != S_DATA)  bit_idx <= '0;
            else if (bit_end)     bit_idx <= bit_idx + 1'b1;
            if (state != S_STOP)  stop_idx <= 1'b0;
            else if (bit_end)     stop_idx <= 1'b1;
            if (state == S_DATA && samp2)
                shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (state == S_PARITY && samp2)
                par_bit <= maj;
            if (state == S_IDLE)
                ferr_acc <= 1'b0;
            else if (state == S_STOP && samp2 && !maj)
                ferr_acc <= 1'b1;
        end
    end

    // Held output word: a delivery collides with a held word only when the consumer is not taking it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                frame_err  <= ferr_acc | ~maj;
                parity_err <= perr_now;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (deliver && rx_valid && !rx_ready) overrun <= 1'b1;
            else if (err_clr)                     overrun <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate; BIT_CYC = CLK_FREQ/BAUD (integer division, 5208 at defaults), HALF = BIT_CYC/2.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..9, data bits per frame.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 clk  input  1  system clock; the single clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 sci_rx  input  1  serial line, idle high, LSB first; asynchronous to clk.
REQ-009 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-010 err_clr  input  1  single-cycle pulse clearing the sticky overrun flag.
REQ-011 rx_data  output  DATA_BITS  received word.
REQ-012 rx_valid  output  1  rx_data, frame_err and parity_err are valid.
REQ-013 frame_err  output  1  held word had a stop bit sampled low.
REQ-014 parity_err  output  1  held word failed parity; constant 0 when PARITY=0.
REQ-015 overrun  output  1  sticky: a completed word was dropped.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 sci_rx SHALL pass through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value rxs.
REQ-018 A bit counter SHALL run 0..BIT_CYC-1 per bit; rxs sampled at counts HALF-1, HALF, HALF+1; the bit value is the 2-of-3 majority.
REQ-019 States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-020 IDLE -> START on rxs==0, with the bit counter starting at 0 on that cycle.
REQ-021 START: majority 1 (glitch) -> IDLE after the third sample, nothing delivered; majority 0 -> DATA at end of bit period.
REQ-022 DATA: DATA_BITS bits shifted in LSB first; then PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: error when the XOR of data bits and parity bit is 0 (odd) or 1 (even).
REQ-024 STOP: STOP_BITS stop bits checked; any stop bit with majority 0 sets frame_err for that word.
REQ-025 After the third sample of the final stop bit: stop good -> IDLE on the next cycle; stop bad -> BRK_WAIT, which returns to IDLE only once rxs==1.
REQ-026 The word SHALL be delivered on the clock edge after the final stop bit's third sample, with frame_err and parity_err registered alongside it.
REQ-027 Delivery sets rx_valid=1; rx_valid, rx_data and error flags are held stable until a cycle with rx_valid && rx_ready, after which rx_valid=0.
REQ-028 Delivery when rx_valid=1 and rx_ready=0: new word dropped, held word unchanged, overrun set to 1.
REQ-029 Delivery in the same cycle as acceptance: new word loaded, rx_valid stays 1, no overrun.
REQ-030 overrun is cleared only by err_clr or reset; if err_clr coincides with a new overrun event, overrun stays 1.
REQ-031 Receiver SHALL keep receiving while rx_valid=1; output backpressure never stalls the line FSM.

Reset
REQ-032 While rst_n=0: state IDLE, counters 0, synchronizer 1, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-033 Reset asserted mid-frame aborts the frame with no delivery; after release, a new frame is detected only after rxs has gone low from IDLE.

Verification
REQ-034 Defaults, frame 0x42 at 5208 clk/bit (start 0, bits 0,1,0,0,0,0,1,0, stop 1), rx_ready=1 -> one rx_valid pulse, rx_data=0x42, frame_err=0, parity_err=0, rx_valid rises within BIT_CYC of the stop-bit mid-point.
REQ-035 Low pulse of 1000 clk on idle line -> no rx_valid, busy drops by count HALF+2, next 0x42 frame received correctly.
REQ-036 PARITY=2, frame 0x42 with parity bit 1 -> rx_data=0x42, parity_err=1; same frame with parity bit 0 -> parity_err=0.
REQ-037 Frame 0x42 with stop bit 0, line held low 3 bit times then high -> rx_valid with frame_err=1, state BRK_WAIT until high, no spurious second word.
REQ-038 rx_ready=0, frames 0x42 then 0x13 -> rx_data stays 0x42, overrun=1; err_clr pulse -> overrun=0; rx_ready=1 -> rx_valid falls.
REQ-039 rst_n low mid-DATA of 0x42 then released -> all outputs at reset values, no delivery; a following 0x55 frame is received as 0x55.
